// File: rtl/apb_mux_pkg.sv
// Shared types and constants for the APB domain decoder/multiplexer.
package apb_mux_pkg;

  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned STRB_W   = 4;
  localparam int unsigned PROT_W   = 3;
  localparam int unsigned DEC_W    = 4;
  localparam int unsigned MAX_PORT = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SETUP  = 2'b01,
    ACCESS = 2'b10,
    ABORT  = 2'b11
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'b00,
    ERR_UNMAPPED = 2'b01,
    ERR_TIMEOUT  = 2'b10
  } err_code_e;

  // Upstream completion payload returned to the APB master.
  typedef struct packed {
    logic [DATA_W-1:0] rdata;
    logic              ready;
    logic              slverr;
  } apb_rsp_t;

endpackage

// File: rtl/apb_domain_mux_if.sv
// Upstream APB port plus the fanned-out downstream slave bus of one domain.
interface apb_domain_mux_if
  import apb_mux_pkg::*;
#(
  parameter int unsigned NPORT = 16
);

  logic [ADDR_W-1:0]       paddr;
  logic [DATA_W-1:0]       pwdata;
  logic                    psel;
  logic                    penable;
  logic                    pwrite;
  logic [STRB_W-1:0]       pstrb;
  logic [PROT_W-1:0]       pprot;
  logic [DATA_W-1:0]       prdata;
  logic                    pready;
  logic                    pslverr;

  logic [NPORT-1:0]        s_psel;
  logic                    s_penable;
  logic [NPORT*DATA_W-1:0] s_prdata;
  logic [NPORT-1:0]        s_pready;
  logic [NPORT-1:0]        s_pslverr;

  // Upstream bridge driving the domain.
  modport master (
    output paddr, pwdata, psel, penable, pwrite, pstrb, pprot,
    input  prdata, pready, pslverr
  );

  // The mux itself: slave upstream, master downstream.
  modport slave (
    input  paddr, psel, penable,
    output prdata, pready, pslverr,
    output s_psel, s_penable,
    input  s_prdata, s_pready, s_pslverr
  );

  // Peripherals read the shared address/data/strobe/prot lines directly.
  modport periph (
    input  paddr, pwdata, pwrite, pstrb, pprot, s_psel, s_penable,
    output s_prdata, s_pready, s_pslverr
  );

endinterface

// File: rtl/apb_mux_timeout.sv
// Access-phase wait counter; requests an abort after TIMEOUT stalled cycles.
module apb_mux_timeout #(
  parameter int unsigned TIMEOUT = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic access,
  input  logic stall,
  output logic abort_req_c
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q;

  // Cleared whenever the bus is not in an access cycle, so each ACCESS starts at 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (!access) begin
      cnt_q <= '0;
    end else if (stall) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign abort_req_c = stall & (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/apb_domain_mux.sv
// APB decoder/mux for one peripheral domain with unmapped-slot and stall-timeout errors.
// Define APB_MUX_TIMEOUT_EN to build the wait counter and the ABORT path.
module apb_domain_mux
  import apb_mux_pkg::*;
#(
  parameter int unsigned NPORT   = 16,
  parameter logic [15:0] PORT_EN = 16'h0001,
  parameter int unsigned DEC_LSB = 12,
  parameter int unsigned TIMEOUT = 256
) (
  input  logic              apb_root_clk,
  input  logic              apb_root_rst,
  apb_domain_mux_if.slave   bus,
  input  logic              err_clr,
  output logic              err_irq,
  output logic [1:0]        err_code,
  output logic [ADDR_W-1:0] err_addr
);

  if (NPORT < 1 || NPORT > MAX_PORT || TIMEOUT < 2 || TIMEOUT > 65535 ||
      DEC_LSB + DEC_W > ADDR_W) begin : g_bad_cfg
    $error("apb_domain_mux: parameter out of range");
  end

  state_e            state_q, state_d;
  logic [DEC_W-1:0]  idx;
  logic              mapped_c;
  logic              setup_c, access_c, first_c, abort_c;
  logic              abort_req_c;
  logic              err_ev_c;
  apb_rsp_t          rsp_c;

  logic [DATA_W-1:0]   rdata_slot [MAX_PORT];
  logic [MAX_PORT-1:0] ready_slot, err_slot;

  // Pad the slave response vectors to 16 slots so the 4-bit index always fits.
  assign ready_slot = MAX_PORT'(bus.s_pready);
  assign err_slot   = MAX_PORT'(bus.s_pslverr);

  for (genvar g = 0; g < MAX_PORT; g++) begin : g_slot
    if (g < NPORT) begin : g_on
      assign rdata_slot[g] = bus.s_prdata[g*DATA_W +: DATA_W];
    end else begin : g_off
      assign rdata_slot[g] = '0;
    end
  end

  assign idx      = bus.paddr[DEC_LSB +: DEC_W];
  assign mapped_c = (32'(idx) < NPORT) && PORT_EN[idx];

  // state_q records what the previous cycle established; the current phase is
  // qualified here with the live psel/penable.
  always_comb begin
    setup_c  = bus.psel & ~bus.penable & (state_q != ABORT);
    access_c = bus.psel & bus.penable & ((state_q == SETUP) || (state_q == ACCESS));
    first_c  = access_c & (state_q == SETUP);
    abort_c  = bus.psel & (state_q == ABORT);
  end

  // Upstream response: slave mux, unmapped termination or abort.
  always_comb begin
    rsp_c = '0;
    if (abort_c) begin
      rsp_c.ready  = 1'b1;
      rsp_c.slverr = 1'b1;
    end else if (access_c && mapped_c) begin
      rsp_c.rdata  = rdata_slot[idx];
      rsp_c.ready  = ready_slot[idx];
      rsp_c.slverr = err_slot[idx];
    end else if (first_c && !mapped_c) begin
      rsp_c.ready  = 1'b1;
      rsp_c.slverr = 1'b1;
    end
  end

  assign bus.prdata  = rsp_c.rdata;
  assign bus.pready  = rsp_c.ready;
  assign bus.pslverr = rsp_c.slverr;

  for (genvar g = 0; g < NPORT; g++) begin : g_psel
    assign bus.s_psel[g] = (setup_c | access_c) & mapped_c & (idx == DEC_W'(g));
  end
  assign bus.s_penable = access_c;

  always_comb begin
    state_d = state_q;
    if (!bus.psel) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (!bus.penable) state_d = SETUP;
        end
        SETUP, ACCESS: begin
          if (!bus.penable)     state_d = SETUP;
          else if (rsp_c.ready) state_d = IDLE;
          else if (abort_req_c) state_d = ABORT;
          else                  state_d = ACCESS;
        end
        ABORT:   state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

`ifdef APB_MUX_TIMEOUT_EN
  apb_mux_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk         (apb_root_clk),
    .rst         (apb_root_rst),
    .access      (access_c),
    .stall       (access_c & ~rsp_c.ready),
    .abort_req_c (abort_req_c)
  );
`else
  assign abort_req_c = 1'b0;
`endif

  assign err_ev_c = abort_c | (first_c & ~mapped_c);

  always_ff @(posedge apb_root_clk) begin
    if (apb_root_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // First mux-generated error sticks; a clear coinciding with a new error keeps the new one.
  always_ff @(posedge apb_root_clk) begin
    if (apb_root_rst) begin
      err_irq  <= 1'b0;
      err_code <= ERR_NONE;
      err_addr <= '0;
    end else if (err_ev_c && (!err_irq || err_clr)) begin
      err_irq  <= 1'b1;
      err_code <= abort_c ? ERR_TIMEOUT : ERR_UNMAPPED;
      err_addr <= bus.paddr;
    end else if (err_clr) begin
      err_irq  <= 1'b0;
      err_code <= ERR_NONE;
      err_addr <= '0;
    end
  end

endmodule

// File: tb/tb_apb_domain_mux.sv
// Scoreboard bench for apb_domain_mux: 4 ports, slots 0 and 2 enabled, TIMEOUT = 4.
module tb_apb_domain_mux;

  localparam int unsigned NP  = 4;
  localparam int unsigned TMO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        err_clr;
  logic        err_irq;
  logic [1:0]  err_code;
  logic [31:0] err_addr;

  apb_domain_mux_if #(.NPORT(NP)) bus ();

  apb_domain_mux #(
    .NPORT   (NP),
    .PORT_EN (16'h0005),
    .DEC_LSB (12),
    .TIMEOUT (TMO)
  ) dut (
    .apb_root_clk (clk),
    .apb_root_rst (rst),
    .bus          (bus),
    .err_clr      (err_clr),
    .err_irq      (err_irq),
    .err_code     (err_code),
    .err_addr     (err_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]   rdata;
    logic          err;
    int            cycles;
    logic [NP-1:0] setup_psel;
    logic [NP-1:0] done_psel;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic expect_xfer(input logic [31:0] rdata, input logic err, input int cycles,
                             input logic [NP-1:0] setup_psel, input logic [NP-1:0] done_psel);
    exp_t e;
    e.rdata      = rdata;
    e.err        = err;
    e.cycles     = cycles;
    e.setup_psel = setup_psel;
    e.done_psel  = done_psel;
    sb.push_back(e);
  endtask

  // One APB transfer; the addressed slave goes ready on access cycle wait_n+1 (never if < 0).
  task automatic xfer(input logic [31:0] addr, input logic wr, input int wait_n,
                      input int clr_k, input logic slv_err);
    logic [3:0]    slot;
    logic [NP-1:0] mask;
    logic [NP-1:0] setup_psel;
    logic [NP-1:0] done_psel;
    logic [31:0]   rdata;
    logic          perr;
    logic          done;
    int            k;
    exp_t          e;
    slot = addr[15:12];
    mask = NP'(1) << slot;
    @(posedge clk); #1;
    bus.paddr   = addr;
    bus.pwrite  = wr;
    bus.pwdata  = ~addr;
    bus.pstrb   = 4'hF;
    bus.psel    = 1'b1;
    bus.penable = 1'b0;
    @(negedge clk);
    setup_psel = bus.s_psel;
    done = 1'b0;
    k = 0;
    done_psel = '0;
    rdata = '0;
    perr = 1'b0;
    while (!done && k < 40) begin
      @(posedge clk); #1;
      k++;
      bus.penable   = 1'b1;
      bus.s_pready  = (wait_n >= 0 && k > wait_n) ? mask : '0;
      bus.s_pslverr = slv_err ? mask : '0;
      err_clr       = (k == clr_k);
      @(negedge clk);
      if (k == 1) check("s_penable", 32'(bus.s_penable), 32'd1);
      if (bus.pready) begin
        done      = 1'b1;
        done_psel = bus.s_psel;
        rdata     = bus.prdata;
        perr      = bus.pslverr;
      end
    end
    check("xfer_done", 32'(done), 32'd1);
    check("sb_pending", 32'(sb.size() > 0), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      if (done) begin
        check("prdata", rdata, e.rdata);
        check("pslverr", 32'(perr), 32'(e.err));
        check("cycles", 32'(k), 32'(e.cycles));
        check("psel_setup", 32'(setup_psel), 32'(e.setup_psel));
        check("psel_done", 32'(done_psel), 32'(e.done_psel));
      end
    end
    @(posedge clk); #1;
    bus.psel      = 1'b0;
    bus.penable   = 1'b0;
    bus.s_pready  = '0;
    bus.s_pslverr = '0;
    err_clr       = 1'b0;
  endtask

  task automatic check_err(input string tag, input logic irq, input logic [1:0] code,
                           input logic [31:0] addr);
    @(negedge clk);
    check({tag, "_irq"}, 32'(err_irq), 32'(irq));
    check({tag, "_code"}, 32'(err_code), 32'(code));
    check({tag, "_addr"}, err_addr, addr);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_s_psel"}, 32'(bus.s_psel), 32'd0);
    check({tag, "_s_penable"}, 32'(bus.s_penable), 32'd0);
    check({tag, "_pready"}, 32'(bus.pready), 32'd0);
    check({tag, "_pslverr"}, 32'(bus.pslverr), 32'd0);
    check({tag, "_prdata"}, bus.prdata, 32'd0);
    check({tag, "_irq"}, 32'(err_irq), 32'd0);
    check({tag, "_code"}, 32'(err_code), 32'd0);
    check({tag, "_addr"}, err_addr, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.paddr     = '0;
    bus.pwdata    = '0;
    bus.psel      = 1'b0;
    bus.penable   = 1'b0;
    bus.pwrite    = 1'b0;
    bus.pstrb     = '0;
    bus.pprot     = '0;
    bus.s_prdata  = {32'hA5A5_0003, 32'hA5A5_0002, 32'hA5A5_0001, 32'hA5A5_0000};
    bus.s_pready  = '0;
    bus.s_pslverr = '0;
    err_clr       = 1'b0;
    rst           = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("reset");

    // Mapped read, slot 2, two wait states.
    expect_xfer(32'hA5A5_0002, 1'b0, 3, 4'b0100, 4'b0100);
    xfer(32'h4002_2010, 1'b0, 2, 0, 1'b0);
    check_err("mapped", 1'b0, 2'b00, 32'h0);

    // Slave error is passed through but not captured.
    expect_xfer(32'hA5A5_0000, 1'b1, 1, 4'b0001, 4'b0001);
    xfer(32'h4002_0004, 1'b1, 0, 0, 1'b1);
    check_err("slverr", 1'b0, 2'b00, 32'h0);

    // Ready on access cycle TIMEOUT completes normally.
    expect_xfer(32'hA5A5_0000, 1'b0, TMO, 4'b0001, 4'b0001);
    xfer(32'h4002_0000, 1'b0, TMO - 1, 0, 1'b0);
    check_err("boundary", 1'b0, 2'b00, 32'h0);

`ifdef APB_MUX_TIMEOUT_EN
    expect_xfer(32'h0, 1'b1, TMO + 1, 4'b0001, 4'b0000);
    xfer(32'h4002_0008, 1'b0, -1, 0, 1'b0);
    check_err("timeout", 1'b1, 2'b10, 32'h4002_0008);
`else
    expect_xfer(32'hA5A5_0000, 1'b0, 11, 4'b0001, 4'b0001);
    xfer(32'h4002_0008, 1'b0, 10, 0, 1'b0);
    check_err("long_stall", 1'b0, 2'b00, 32'h0);
`endif

    // Standalone clear.
    @(posedge clk); #1 err_clr = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0;
    check_err("clear", 1'b0, 2'b00, 32'h0);

    // Unmapped write to disabled slot 1.
    expect_xfer(32'h0, 1'b1, 1, 4'b0000, 4'b0000);
    xfer(32'h4002_1000, 1'b1, -1, 0, 1'b0);
    check_err("unmapped", 1'b1, 2'b01, 32'h4002_1000);

`ifdef APB_MUX_TIMEOUT_EN
    // A later timeout must not overwrite the sticky record.
    expect_xfer(32'h0, 1'b1, TMO + 1, 4'b0001, 4'b0000);
    xfer(32'h4002_0000, 1'b0, -1, 0, 1'b0);
    check_err("sticky", 1'b1, 2'b01, 32'h4002_1000);
`endif

    // Clear coinciding with a new unmapped error keeps the new error.
    expect_xfer(32'h0, 1'b1, 1, 4'b0000, 4'b0000);
    xfer(32'h4002_3000, 1'b1, -1, 1, 1'b0);
    check_err("clr_new", 1'b1, 2'b01, 32'h4002_3000);

    // Reset in the middle of an access with psel held.
    @(posedge clk); #1;
    bus.paddr   = 32'h4002_0000;
    bus.pwrite  = 1'b0;
    bus.psel    = 1'b1;
    bus.penable = 1'b0;
    @(posedge clk); #1 bus.penable = 1'b1;
    @(negedge clk);
    check("rst_pre_psel", 32'(bus.s_psel), 32'h1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("rst_mid");
    @(negedge clk);
    check("rst_hold_psel", 32'(bus.s_psel), 32'd0);
    @(posedge clk); #1;
    bus.psel    = 1'b0;
    bus.penable = 1'b0;

    expect_xfer(32'hA5A5_0002, 1'b0, 1, 4'b0100, 4'b0100);
    xfer(32'h4002_2000, 1'b0, 0, 0, 1'b0);
    check_err("post_rst", 1'b0, 2'b00, 32'h0);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
